// File: rtl/sfr_arb.sv
// Two-master round-robin arbiter in front of a single SFR block; each access is one grant cycle plus one ack cycle.
// Optional bus lock (lock0/lock1 ports, sticky tie-break) is built only when SFR_ARB_LOCK_EN is defined.
module sfr_arb #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 16
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          req0,
  input  logic          req1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic          rd0,
  input  logic          rd1,
  input  logic [1:0]    wr0,
  input  logic [1:0]    wr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
`ifdef SFR_ARB_LOCK_EN
  input  logic          lock0,
  input  logic          lock1,
`endif
  output logic          ack0,
  output logic          ack1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          sel,
  output logic [AW-1:0] addr,
  output logic          r,
  output logic [1:0]    w,
  output logic [DW-1:0] dwrite,
  input  logic [DW-1:0] sfr_data
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  state_t        state_q, state_d;
  logic          sel_q, sel_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          r_q, r_d;
  logic [1:0]    w_q, w_d;
  logic [DW-1:0] dwrite_q, dwrite_d;
  logic          ack0_q, ack0_d;
  logic          ack1_q, ack1_d;
  logic [DW-1:0] rdata0_q, rdata0_d;
  logic [DW-1:0] rdata1_q, rdata1_d;
  logic          last_q, last_d;
  logic          tie_pick1_c;
  logic          freeze_c;
  logic          gnt0_c;
  logic          gnt1_c;
`ifdef SFR_ARB_LOCK_EN
  logic          lock_v_q, lock_v_d;
  logic          lock_own_q, lock_own_d;
`endif

  // Tie-break: master not served last, overridden by a still-held lock.
  always_comb begin
    tie_pick1_c = ~last_q;
    freeze_c    = 1'b0;
`ifdef SFR_ARB_LOCK_EN
    if (lock_v_q && (lock_own_q ? lock1 : lock0)) begin
      tie_pick1_c = lock_own_q;
      freeze_c    = 1'b1;
    end
`endif
    gnt1_c = req1 & (~req0 | tie_pick1_c);
    gnt0_c = req0 & ~gnt1_c;
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = 1'b0;
    addr_d   = '0;
    r_d      = 1'b0;
    w_d      = 2'b00;
    dwrite_d = '0;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    last_d   = last_q;
`ifdef SFR_ARB_LOCK_EN
    lock_v_d   = lock_v_q;
    lock_own_d = lock_own_q;
`endif
    case (state_q)
      IDLE: begin
        if (gnt0_c) begin
          state_d  = GNT0;
          sel_d    = 1'b1;
          addr_d   = addr0;
          r_d      = rd0;
          w_d      = wr0;
          dwrite_d = wdata0;
          if (!freeze_c) last_d = 1'b0;
        end else if (gnt1_c) begin
          state_d  = GNT1;
          sel_d    = 1'b1;
          addr_d   = addr1;
          r_d      = rd1;
          w_d      = wr1;
          dwrite_d = wdata1;
          if (!freeze_c) last_d = 1'b1;
        end
      end
      // Completion uses the registered strobe, so a dropped req cannot abort it.
      GNT0: begin
        state_d = IDLE;
        ack0_d  = 1'b1;
        if (r_q) rdata0_d = sfr_data;
`ifdef SFR_ARB_LOCK_EN
        lock_v_d   = lock0;
        lock_own_d = 1'b0;
`endif
      end
      GNT1: begin
        state_d = IDLE;
        ack1_d  = 1'b1;
        if (r_q) rdata1_d = sfr_data;
`ifdef SFR_ARB_LOCK_EN
        lock_v_d   = lock1;
        lock_own_d = 1'b1;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q  <= IDLE;
      sel_q    <= 1'b0;
      addr_q   <= '0;
      r_q      <= 1'b0;
      w_q      <= 2'b00;
      dwrite_q <= '0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      last_q   <= 1'b1;
`ifdef SFR_ARB_LOCK_EN
      lock_v_q   <= 1'b0;
      lock_own_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      addr_q   <= addr_d;
      r_q      <= r_d;
      w_q      <= w_d;
      dwrite_q <= dwrite_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      last_q   <= last_d;
`ifdef SFR_ARB_LOCK_EN
      lock_v_q   <= lock_v_d;
      lock_own_q <= lock_own_d;
`endif
    end
  end

  assign sel    = sel_q;
  assign addr   = addr_q;
  assign r      = r_q;
  assign w      = w_q;
  assign dwrite = dwrite_q;
  assign ack0   = ack0_q;
  assign ack1   = ack1_q;
  assign rdata0 = rdata0_q;
  assign rdata1 = rdata1_q;

endmodule

// File: tb/tb_sfr_arb.sv
// Directed bench for sfr_arb: single accesses, round-robin stream, reset mid-grant, and lock when SFR_ARB_LOCK_EN is defined.
module tb_sfr_arb;
  localparam int unsigned AW = 8;
  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          nreset = 1'b0;
  logic          req0 = 1'b0, req1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic          rd0 = 1'b0, rd1 = 1'b0;
  logic [1:0]    wr0 = 2'b00, wr1 = 2'b00;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic [DW-1:0] sfr_data = '0;
`ifdef SFR_ARB_LOCK_EN
  logic          lock0 = 1'b0, lock1 = 1'b0;
`endif
  logic          ack0, ack1, sel, r;
  logic [DW-1:0] rdata0, rdata1, dwrite;
  logic [AW-1:0] addr;
  logic [1:0]    w;

  int n_cmp = 0;
  int n_err = 0;

  sfr_arb #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .nreset(nreset),
    .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
    .rd0(rd0), .rd1(rd1), .wr0(wr0), .wr1(wr1),
    .wdata0(wdata0), .wdata1(wdata1),
`ifdef SFR_ARB_LOCK_EN
    .lock0(lock0), .lock1(lock1),
`endif
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .sel(sel), .addr(addr), .r(r), .w(w), .dwrite(dwrite),
    .sfr_data(sfr_data)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    req0 = 1'b0; req1 = 1'b0; rd0 = 1'b0; rd1 = 1'b0;
    wr0 = 2'b00; wr1 = 2'b00; wdata0 = '0; wdata1 = '0;
  endtask

  task automatic do_reset();
    nreset = 1'b0;
    step();
    step();
    nreset = 1'b1;
  endtask

  initial begin
    do_reset();
    check_val("rst_ctl", {28'd0, sel, r, ack0, ack1}, 32'd0);
    check_val("rst_addr_w", {22'd0, addr, w}, 32'd0);
    check_val("rst_dwrite", {16'd0, dwrite}, 32'd0);
    check_val("rst_rdata", {rdata0, rdata1}, 32'd0);

    // Master 0 read
    req0 = 1'b1; addr0 = 8'h14; rd0 = 1'b1; sfr_data = 16'hBEEF;
    step();
    check_val("rd0_gnt", {27'd0, sel, r, w, ack0}, {27'd0, 1'b1, 1'b1, 2'b00, 1'b0});
    check_val("rd0_addr", {24'd0, addr}, 32'h14);
    step();
    check_val("rd0_ack", {29'd0, sel, ack0, ack1}, {29'd0, 1'b0, 1'b1, 1'b0});
    check_val("rd0_rdata", {16'd0, rdata0}, 32'hBEEF);
    check_val("rd0_ackbus", {22'd0, addr, w}, 32'd0);
    clear_reqs();
    step();
    check_val("rd0_idle", {30'd0, sel, ack0}, 32'd0);

    // Master 1 low-byte write
    req1 = 1'b1; addr1 = 8'h00; wr1 = 2'b01; wdata1 = 16'h00A5; sfr_data = 16'h1234;
    step();
    check_val("wr1_gnt", {28'd0, sel, r, w}, {28'd0, 1'b1, 1'b0, 2'b01});
    check_val("wr1_dwrite", {16'd0, dwrite}, 32'h00A5);
    step();
    check_val("wr1_ack", {29'd0, sel, ack0, ack1}, {29'd0, 1'b0, 1'b0, 1'b1});
    check_val("wr1_rdata", {16'd0, rdata1}, 32'h0);
    check_val("wr1_dw_clr", {16'd0, dwrite}, 32'h0);
    clear_reqs();
    step();

    // Empty access from master 0 still runs a full grant
    req0 = 1'b1; addr0 = 8'h33;
    step();
    check_val("nop_gnt", {28'd0, sel, r, w}, {28'd0, 1'b1, 1'b0, 2'b00});
    step();
    check_val("nop_ack", {30'd0, ack0, ack1}, {30'd0, 1'b1, 1'b0});
    check_val("nop_rdata", {16'd0, rdata0}, 32'hBEEF);
    clear_reqs();
    step();

    // Tie with master 0 served last -> master 1; reset during its grant
    req0 = 1'b1; req1 = 1'b1; addr0 = 8'h01; addr1 = 8'h02; rd0 = 1'b1; rd1 = 1'b1;
    step();
    check_val("rst_pre", {23'd0, sel, addr}, {23'd0, 1'b1, 8'h02});
    #1 nreset = 1'b0;
    #1;
    check_val("rst_mid_ctl", {28'd0, sel, r, ack0, ack1}, 32'd0);
    check_val("rst_mid_bus", {22'd0, addr, w}, 32'd0);
    check_val("rst_mid_rdata", {rdata0, rdata1}, 32'd0);
    #2 nreset = 1'b1;
    step();
    check_val("post_rst_gnt", {22'd0, sel, ack1, addr}, {22'd0, 1'b1, 1'b0, 8'h01});
    step();
    check_val("post_rst_ack", {30'd0, ack0, ack1}, {30'd0, 1'b1, 1'b0});
    clear_reqs();
    step();

    // Continuous contention from reset: 8 accesses alternating 0,1,...
    do_reset();
    req0 = 1'b1; req1 = 1'b1; rd0 = 1'b1; rd1 = 1'b1;
    addr0 = 8'hA0; addr1 = 8'hB1;
    for (int i = 0; i < 16; i++) begin
      logic m1;
      sfr_data = 16'(16'h1000 + i);
      m1 = ((i / 2) % 2) == 1;
      step();
      if (i % 2 == 0) begin
        check_val($sformatf("rr_gnt%0d", i), {23'd0, sel, addr}, {23'd0, 1'b1, (m1 ? 8'hB1 : 8'hA0)});
        check_val($sformatf("rr_noack%0d", i), {30'd0, ack0, ack1}, 32'd0);
      end else begin
        check_val($sformatf("rr_ack%0d", i), {29'd0, sel, ack0, ack1}, {29'd0, 1'b0, ~m1, m1});
        check_val($sformatf("rr_rdata%0d", i), {16'd0, (m1 ? rdata1 : rdata0)}, 32'(16'h1000 + i));
      end
    end
    clear_reqs();
    step();

`ifdef SFR_ARB_LOCK_EN
    // Lock held by master 0 keeps winning ties; pointer resumes after release
    do_reset();
    req0 = 1'b1; req1 = 1'b1; lock0 = 1'b1;
    addr0 = 8'hA0; addr1 = 8'hB1;
    for (int i = 0; i < 8; i++) begin
      step();
      if (i % 2 == 0)
        check_val($sformatf("lk_gnt%0d", i), {23'd0, sel, addr}, {23'd0, 1'b1, 8'hA0});
      else
        check_val($sformatf("lk_ack%0d", i), {30'd0, ack0, ack1}, {30'd0, 1'b1, 1'b0});
    end
    lock0 = 1'b0;
    step();
    check_val("lk_rel_gnt", {23'd0, sel, addr}, {23'd0, 1'b1, 8'hB1});
    step();
    check_val("lk_rel_ack", {30'd0, ack0, ack1}, {30'd0, 1'b0, 1'b1});
    clear_reqs();
    step();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Protocol invariants checked every cycle
  logic sel_prev = 1'b0;
  always @(negedge clk) begin
    if (ack0 && ack1) begin
      n_err++;
      $display("FAIL ack_excl: got ack0=%0b ack1=%0b expected not both", ack0, ack1);
    end
    if (sel && sel_prev) begin
      n_err++;
      $display("FAIL sel_back2back: got sel high two cycles expected single-cycle");
    end
    sel_prev <= sel;
  end
endmodule
